star_field: RTL and testbench
=============================

Name: star_field

Overview:
- Scrolling background star field for the SubAdventure VGA display.
- Holds NUM_STARS square stars of STAR_SIZE pixels. Each frame it drifts every star left at a per-star speed, and wraps stars that leave the screen back to the right edge at a pseudo-random row.
- Per pixel it outputs a registered "star" hit from hcount/vcount, which feeds the pixel colour mux beneath the sub and rock layers.

Parameters:
- NUM_STARS, 8, number of stars (1..16)
- STAR_SIZE, 3, star edge length in pixels (1..8)
- H_RES, 640, visible width in pixels
- V_RES, 480, visible height in pixels
- MAX_SPEED, 3, speeds cycle 1..MAX_SPEED by star index
- LFSR_SEED, 16'hACE1, reset value of the row generator (must be non-zero)

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- blank  in  1  high outside the visible area
- hcount  in  11 signed  current pixel column
- vcount  in  11 signed  current pixel row
- star  out  1  registered: current pixel lies on a visible star
- busy  out  1  high while per-frame update runs
- overrun  out  1  sticky: frame_tick arrived while busy; cleared only by reset

Behaviour:
- Reset values:
  - x[i] = (i*H_RES)/NUM_STARS
  - y[i] = (i*97+13) mod (V_RES-STAR_SIZE), computed at elaboration
  - lfsr = LFSR_SEED; state = IDLE; star = 0; busy = 0; overrun = 0; vis[i] = 1
- Position storage: x is 10 bits unsigned, y is 9 bits unsigned. speed[i] = 1 + (i mod MAX_SPEED), constant.
- Draw path:
  - hit_i = hcount>=x[i] & hcount<x[i]+STAR_SIZE & vcount>=y[i] & vcount<y[i]+STAR_SIZE & vis[i].
  - star <= ~blank & OR(hit_i), registered with exactly 1 cycle latency.
  - Comparisons use 12-bit signed arithmetic, so negative hcount/vcount never hit.
- FSM, two states:
  - IDLE: frame_tick -> UPDATE, idx=0, busy=1.
  - UPDATE: one star per cycle at index idx; when idx==NUM_STARS-1 -> IDLE, busy=0 on the following cycle. An update takes NUM_STARS cycles.
- Star update, per star:
  - If x[idx] >= speed: x <= x - speed.
  - Else (wrap): x <= x + H_RES - speed, and y <= lfsr[8:0]. If that value >= V_RES-STAR_SIZE, y <= lfsr[8:0] - (V_RES/2).
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances on every UPDATE cycle and holds in IDLE.
- Boundary conditions:
  - x==speed moves to 0 without wrapping; x<speed wraps.
  - A star is never drawn past H_RES-1+STAR_SIZE.
  - frame_tick while busy is ignored and sets overrun.
  - frame_tick on the last UPDATE cycle is also ignored and sets overrun.
  - Star positions change during the update, but only within vertical blank, so no tearing.
  - Reset mid-UPDATE returns every register to its reset value immediately.

Optional Feature:
- Macro STAR_TWINKLE_EN.
- Defined: during UPDATE, vis[idx] <= lfsr[15] | lfsr[7], so each star is hidden on roughly 25% of frames. vis is updated in the same cycle as that star's position.
- Undefined: vis[i] is constant 1, and no vis registers are synthesised.

Decomposition:
- Shared package (e.g. display_pkg) holds:
  - H_RES/V_RES defaults
  - hcount/vcount width constant (11)
  - position width constants (10/9)
  - LFSR tap mask constant
- Natural sub-module: star_lfsr, the 16-bit LFSR with advance enable and seed parameter, reused by later random spawners.
- Hit comparators stay inline in a generate loop.

Test Plan:
- Reset then idle, default parameters:
  - star0 sits at (0,13); hcount=1, vcount=14, blank=0 -> star=1 one cycle later.
  - Same pixel with blank=1 -> star=0.
- Single frame_tick:
  - busy goes high for 8 cycles.
  - Afterwards x[1] = 80-2 = 78 and x[2] = 160-3 = 157.
  - Probe pixel (78,110) -> star=1.
- Wrap: star0 with speed 1 at x=0, then frame_tick:
  - x0 becomes 639.
  - y0 equals the LFSR value sampled on cycle 0, reduced as specified, and is < 477.
  - Probe at (639,y0) -> star=1.
- Overrun: frame_tick, then a second frame_tick 3 cycles later:
  - Only one update occurs, by x deltas.
  - overrun=1 and stays 1 through further frames until rst_n pulses low.
- Reset mid-update: assert rst_n low during UPDATE cycle 4 -> busy=0, star=0, all positions back to reset values immediately.
- STAR_TWINKLE_EN: over 64 frames, star3 must be hidden on at least 1 frame and visible on at least 1 frame. With the macro undefined, star3 is visible on all 64 frames.

Source files
------------

// File: rtl/star_field_pkg.sv
// star_field_pkg: shared display constants and the row-generator LFSR step
// used by the star field and later random spawners.
package star_field_pkg;

   localparam int H_RES_DEF = 640;   // visible width
   localparam int V_RES_DEF = 480;   // visible height
   localparam int CNT_W     = 11;    // signed hcount/vcount width
   localparam int X_W       = 10;    // star column storage
   localparam int Y_W       = 9;     // star row storage
   localparam int LFSR_W    = 16;

   // Right-shifting Fibonacci form of taps 16,14,13,11: those taps land on
   // bits 0,2,3,5 and the feedback enters at bit 15.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/star_lfsr.sv
// star_lfsr: 16-bit Fibonacci LFSR, advances only when adv is high.
// SEED must be non-zero or the register locks up at zero.
module star_lfsr
   import star_field_pkg::*;
#(
   parameter logic [LFSR_W-1:0] SEED = 16'hACE1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              adv,
   output logic [LFSR_W-1:0] q
);

   // step the sequence on request, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= SEED;
      else if (adv) q <= lfsr_next(q);
   end

endmodule

// File: rtl/star_field.sv
// star_field: scrolling star background. Each frame_tick walks the stars one
// per cycle, drifting them left and wrapping them to the right edge at a
// pseudo-random row; the draw path is a registered per-pixel hit test.
// Build option STAR_TWINKLE_EN: each star is also randomly hidden per frame.
module star_field
   import star_field_pkg::*;
#(
   parameter int              NUM_STARS = 8,
   parameter int              STAR_SIZE = 3,
   parameter int              H_RES     = H_RES_DEF,
   parameter int              V_RES     = V_RES_DEF,
   parameter int              MAX_SPEED = 3,
   parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_tick,
   input  logic                    blank,
   input  logic signed [CNT_W-1:0] hcount,
   input  logic signed [CNT_W-1:0] vcount,
   output logic                    star,
   output logic                    busy,
   output logic                    overrun
);

   localparam int IW = (NUM_STARS > 1) ? $clog2(NUM_STARS) : 1;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] UPDATE = 1'b1;

   localparam logic [Y_W-1:0]     Y_LIM  = Y_W'(V_RES - STAR_SIZE);
   localparam logic [Y_W-1:0]     Y_HALF = Y_W'(V_RES / 2);
   localparam logic signed [CNT_W:0] SZ  = (CNT_W+1)'(STAR_SIZE);

   logic [0:0]            state;
   logic [IW-1:0]         idx;
   logic                  upd;
   logic [LFSR_W-1:0]     lfsr;
   logic                  lfsr_unused;
   logic [Y_W-1:0]        y_wrap;
   logic [NUM_STARS-1:0]  hit;
   logic signed [CNT_W:0] hc, vc;

   assign upd  = (state == UPDATE);
   assign busy = upd;

   // one extra sign bit so star bounds up to H_RES-1+STAR_SIZE never overflow
   assign hc = {hcount[CNT_W-1], hcount};
   assign vc = {vcount[CNT_W-1], vcount};

   // only the low row bits (and twinkle bits) are consumed here
   assign lfsr_unused = ^lfsr[LFSR_W-1:Y_W];

   star_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (upd),
      .q     (lfsr)
   );

   // wrap row: rows that would put the star off the bottom fold back up by half a screen
   always_comb begin
      y_wrap = lfsr[Y_W-1:0];
      if (y_wrap >= Y_LIM) y_wrap = lfsr[Y_W-1:0] - Y_HALF;
   end

   // update sequencer: one star per cycle, ticks seen while busy are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= '0;
      end else begin
         case (state)
            IDLE: if (frame_tick) begin
               state <= UPDATE;
               idx   <= '0;
            end
            UPDATE: begin
               if (idx == IW'(NUM_STARS-1)) state <= IDLE;
               else                         idx   <= idx + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // sticky flag for a tick that arrived mid-update (including the last cycle)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  overrun <= 1'b0;
      else if (frame_tick && upd)  overrun <= 1'b1;
   end

   for (genvar i = 0; i < NUM_STARS; i++) begin : g_star
      localparam logic [X_W-1:0] SPD  = X_W'(1 + (i % MAX_SPEED));
      localparam logic [X_W-1:0] X0   = X_W'((i * H_RES) / NUM_STARS);
      localparam logic [Y_W-1:0] Y0   = Y_W'((i * 97 + 13) % (V_RES - STAR_SIZE));
      localparam logic [X_W-1:0] WRAP = X_W'(H_RES) - SPD;

      logic [X_W-1:0]        x;
      logic [Y_W-1:0]        y;
      logic                  sel;
      logic                  vis;
      logic signed [CNT_W:0] xs, ys;

      assign sel = upd && (idx == IW'(i));

      // drift left by this star's speed, or wrap to the right edge at a new row
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            x <= X0;
            y <= Y0;
         end else if (sel) begin
            if (x >= SPD) x <= x - SPD;
            else begin
               x <= x + WRAP;
               y <= y_wrap;
            end
         end
      end

`ifdef STAR_TWINKLE_EN
      logic vis_r;
      // re-roll visibility alongside this star's position update
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)   vis_r <= 1'b1;
         else if (sel) vis_r <= lfsr[15] | lfsr[7];
      end
      assign vis = vis_r;
`else
      assign vis = 1'b1;
`endif

      assign xs = {{(CNT_W+1-X_W){1'b0}}, x};
      assign ys = {{(CNT_W+1-Y_W){1'b0}}, y};

      assign hit[i] = (hc >= xs) && (hc < xs + SZ) &&
                      (vc >= ys) && (vc < ys + SZ) && vis;
   end

   // registered pixel hit, suppressed outside the visible area
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) star <= 1'b0;
      else        star <= ~blank & (|hit);
   end

endmodule

// File: tb/tb_star_field.sv
// tb_star_field: randomized scoreboard bench for star_field with a
// frame-level reference model (whole frame applied at the tick).
module tb_star_field;

   localparam int N  = 8;
   localparam int S  = 3;
   localparam int H  = 640;
   localparam int V  = 480;
   localparam int MS = 3;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               frame_tick = 1'b0;
   logic               blank = 1'b1;
   logic signed [10:0] hcount = '0;
   logic signed [10:0] vcount = '0;
   logic               star, busy, overrun;

   always #5 clk = ~clk;

   star_field #(
      .NUM_STARS(N), .STAR_SIZE(S), .H_RES(H), .V_RES(V),
      .MAX_SPEED(MS), .LFSR_SEED(16'hACE1)
   ) dut (
      .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .blank(blank),
      .hcount(hcount), .vcount(vcount),
      .star(star), .busy(busy), .overrun(overrun)
   );

   typedef struct {
      logic st;
      logic bz;
      logic ov;
      int   tag;
   } exp_t;

   exp_t q[$];
   exp_t me;
   int   tests = 0;
   int   fails = 0;
   int   vis3 = 0;
   int   hid3 = 0;
   bit   pv = 1'b0;
   bit   pv_q = 1'b0;

   // reference model state
   int          mx[N];
   int          my[N];
   bit          mv[N];
   logic [15:0] ml;
   int          rem;
   bit          movr;

   function automatic logic [15:0] lstep(input logic [15:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction

   task automatic mreset();
      for (int k = 0; k < N; k++) begin
         mx[k] = (k * H) / N;
         my[k] = (k * 97 + 13) % (V - S);
         mv[k] = 1'b1;
      end
      ml   = 16'hACE1;
      rem  = 0;
      movr = 1'b0;
   endtask

   function automatic bit mhit(input int h, input int v);
      bit r = 1'b0;
      for (int k = 0; k < N; k++)
         if (mv[k] && h >= mx[k] && h < mx[k] + S && v >= my[k] && v < my[k] + S) r = 1'b1;
      return r;
   endfunction

   // one whole frame: each star in order consumes one LFSR value
   task automatic mframe();
      int sp, yy;
      for (int k = 0; k < N; k++) begin
         sp = 1 + (k % MS);
         if (mx[k] >= sp) mx[k] = mx[k] - sp;
         else begin
            mx[k] = mx[k] + H - sp;
            yy = int'(ml) % 512;
            if (yy >= V - S) yy = yy - V / 2;
            my[k] = yy;
         end
`ifdef STAR_TWINKLE_EN
         mv[k] = ml[15] | ml[7];
`endif
         ml = lstep(ml);
      end
   endtask

   task automatic check(input string nm, input int tag, input logic act, input logic ex);
      tests++;
      if (act !== ex) begin
         fails++;
         $display("FAIL %s tag=%0d: got %b expected %b", nm, tag, act, ex);
      end
   endtask

   // one clock: drive at negedge, predict the post-edge outputs, optionally queue them
   task automatic cyc(input bit tk, input bit bl, input int h, input int v,
                      input bit chk, input int tag);
      exp_t e;
      if (rem > 0) bl = 1'b1;
      frame_tick = tk;
      blank      = bl;
      hcount     = h[10:0];
      vcount     = v[10:0];
      e.st = !bl && mhit(h, v);
      if (rem > 0) begin
         if (tk) movr = 1'b1;
         rem--;
      end else if (tk) begin
         rem = N;
         mframe();
      end
      e.bz  = (rem > 0);
      e.ov  = movr;
      e.tag = tag;
      if (chk) q.push_back(e);
      pv = chk;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cyc(1'b0, 1'b1, 0, 0, 1'b0, 0);
   endtask

   task automatic rnd_probe(input int tag);
      int h, v, k;
      if ($urandom_range(0, 1) == 0) begin
         h = int'($urandom_range(0, H + 8)) - 4;
         v = int'($urandom_range(0, V + 8)) - 4;
      end else begin
         k = int'($urandom_range(0, N - 1));
         h = mx[k] + int'($urandom_range(0, S + 1)) - 1;
         v = my[k] + int'($urandom_range(0, S + 1)) - 1;
      end
      cyc(1'b0, ($urandom_range(0, 3) == 0), h, v, 1'b1, tag);
   endtask

   // output pipeline tag follows the registered star output by one edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pv_q <= 1'b0;
      else        pv_q <= pv;
   end

   // monitor: pop and compare whenever a queued probe's result is presented
   always @(negedge clk) begin
      if (pv_q) begin
         if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard: output with empty queue");
         end else begin
            me = q.pop_front();
            check("star", me.tag, star, me.st);
            check("busy", me.tag, busy, me.bz);
            check("overrun", me.tag, overrun, me.ov);
            if (me.tag == 3) begin
               if (star) vis3++;
               else      hid3++;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      mreset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state / idle draw, including edges of star0 at (0,13)
      cyc(1'b0, 1'b0, 1, 14, 1'b1, 10);
      cyc(1'b0, 1'b1, 1, 14, 1'b1, 11);
      cyc(1'b0, 1'b0, -1, 14, 1'b1, 12);
      cyc(1'b0, 1'b0, 3, 14, 1'b1, 13);
      cyc(1'b0, 1'b0, 0, 12, 1'b1, 14);
      cyc(1'b0, 1'b0, 80, 110, 1'b1, 15);

      // single frame: busy for N cycles, then drift and star0 wrap
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 20);
      for (int k = 0; k < N + 1; k++) cyc(1'b0, 1'b1, 0, 0, 1'b1, 21);
      cyc(1'b0, 1'b0, 78, 110, 1'b1, 22);
      cyc(1'b0, 1'b0, 80, 110, 1'b1, 23);
      cyc(1'b0, 1'b0, mx[2], my[2], 1'b1, 24);
      cyc(1'b0, 1'b0, mx[0], my[0], 1'b1, 25);
      cyc(1'b0, 1'b0, mx[0] + 2, my[0] + 2, 1'b1, 26);
      cyc(1'b0, 1'b0, mx[0] + 3, my[0], 1'b1, 27);

      // tick on the last update cycle is dropped and flags overrun; next one starts
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 30);
      for (int k = 0; k < N - 1; k++) cyc(1'b0, 1'b1, 0, 0, 1'b1, 31);
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 32);
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 33);
      for (int k = 0; k < N + 1; k++) cyc(1'b0, 1'b1, 0, 0, 1'b1, 34);
      for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, mx[k] + S - 1, my[k], 1'b1, 35);

      // asynchronous reset in the middle of an update
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 40);
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b1, 0, 0, 1'b1, 41);
      cyc(1'b0, 1'b1, 0, 0, 1'b0, 0);
      rst_n = 1'b0;
      #1;
      check("rst_busy", 42, busy, 1'b0);
      check("rst_star", 42, star, 1'b0);
      check("rst_overrun", 42, overrun, 1'b0);
      mreset();
      pv = 1'b0;
      frame_tick = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      cyc(1'b0, 1'b0, 1, 14, 1'b1, 43);
      cyc(1'b0, 1'b0, 80, 110, 1'b1, 44);
      cyc(1'b0, 1'b0, 78, 110, 1'b1, 45);

      // second tick three cycles into an update is ignored
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 50);
      cyc(1'b0, 1'b1, 0, 0, 1'b1, 51);
      cyc(1'b0, 1'b1, 0, 0, 1'b1, 51);
      cyc(1'b1, 1'b1, 0, 0, 1'b1, 52);
      for (int k = 0; k < N; k++) cyc(1'b0, 1'b1, 0, 0, 1'b1, 53);
      for (int k = 0; k < N; k++) cyc(1'b0, 1'b0, mx[k] + S - 1, my[k], 1'b1, 54);

      // randomized frames; overrun must stay set, star3 visibility tracked
      for (int f = 0; f < 64; f++) begin
         cyc(1'b1, 1'b1, 0, 0, 1'b1, 60);
         for (int k = 0; k < N + 1; k++) rnd_probe(61);
         cyc(1'b0, 1'b0, mx[3], my[3], 1'b1, 3);
         for (int k = 0; k < 3; k++) rnd_probe(62);
      end

      idle(2);
      tests++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d results never presented, required 0", q.size());
      end

`ifdef STAR_TWINKLE_EN
      tests++;
      if (hid3 < 1) begin
         fails++;
         $display("FAIL twinkle_hidden: star3 hidden on %0d frames, required >=1", hid3);
      end
      tests++;
      if (vis3 < 1) begin
         fails++;
         $display("FAIL twinkle_visible: star3 visible on %0d frames, required >=1", vis3);
      end
`else
      tests++;
      if (vis3 != 64) begin
         fails++;
         $display("FAIL star3_visible: visible on %0d frames, required 64", vis3);
      end
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
